fft_reorder: RTL and testbench

Streaming bit-reversal reorder buffer placed directly after `FftTop`. It accepts complex samples in the FFT's bit-reversed output order and emits each frame in natural frequency order, so benches and downstream blocks no longer reorder in software. Point count and sample width are parameters, and the block uses ping-pong banks so back-to-back frames stream without stalls.

---
 rtl/fft_reorder_pkg.sv | 21 ++
 rtl/fft_reorder_ram.sv | 22 ++
 rtl/fft_reorder.sv | 126 ++++++++++++
 tb/tb_fft_reorder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_reorder_pkg.sv
// Shared types and helpers for the FFT bit-reversal reorder buffer.
package fft_reorder_pkg;

    localparam int unsigned BR_W = 10;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_READ = 1'b1;

    // Reverse the low nbits of value; bits above nbits come back as zero.
    function automatic logic [BR_W-1:0] bitrev(input logic [BR_W-1:0] value,
                                               input int unsigned nbits);
        logic [BR_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < nbits; b++) begin
            r[4'(b)] = value[4'(nbits - 1 - b)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module fft_reorder_ram #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 32
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output in, natural-order frames out.
module fft_reorder
    import fft_reorder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LOG2N = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned AW = LOG2N + 1;
    localparam logic [LOG2N-1:0] CNT_LAST = '1;

    logic [LOG2N-1:0] wcnt;
    logic             wbank;
    logic [1:0]       full;
    logic [1:0]       full_next_c;
    logic             wr_last_c;
    logic [LOG2N-1:0] wr_pos_c;

    state_t           state, state_next;
    logic [LOG2N-1:0] rcnt, rcnt_next;
    logic             rbank, rbank_next;
    logic             rd_last_c;

    logic [DW-1:0]    rdata;

    assign wr_last_c = idata_en && (wcnt == CNT_LAST);
    assign wr_pos_c  = LOG2N'(bitrev(BR_W'(wcnt), LOG2N));

    // Full flags: a bank may be set and the other cleared in the same cycle.
    always_comb begin
        full_next_c = full;
        if (wr_last_c) full_next_c[wbank] = 1'b1;
        if (rd_last_c) full_next_c[rbank] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt  <= '0;
            wbank <= 1'b0;
            full  <= '0;
        end else begin
            full <= full_next_c;
            if (idata_en) begin
                wcnt <= wcnt + 1'b1;
                if (wr_last_c) wbank <= ~wbank;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            rcnt  <= '0;
            rbank <= 1'b0;
        end else begin
            state <= state_next;
            rcnt  <= rcnt_next;
            rbank <= rbank_next;
        end
    end

    always_comb begin
        state_next = state;
        rcnt_next  = rcnt;
        rbank_next = rbank;
        rd_last_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (full[rbank]) begin
                    state_next = ST_READ;
                    rcnt_next  = '0;
                end
            end
            ST_READ: begin
                rcnt_next = rcnt + 1'b1;
                if (rcnt == CNT_LAST) begin
                    rd_last_c  = 1'b1;
                    rbank_next = ~rbank;
                    state_next = full[~rbank] ? ST_READ : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // RAM is addressed from next-state values so data lines up with the READ state.
    fft_reorder_ram #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clock(clock),
        .we   (idata_en),
        .waddr({wbank, wr_pos_c}),
        .wdata({idata_r, idata_i}),
        .re   (state_next == ST_READ),
        .raddr({rbank_next, rcnt_next}),
        .rdata(rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            odata_en <= 1'b0;
            odata_r  <= '0;
            odata_i  <= '0;
        end else begin
            odata_en <= (state == ST_READ);
            odata_r  <= (state == ST_READ) ? rdata[DW-1:WIDTH] : '0;
            odata_i  <= (state == ST_READ) ? rdata[WIDTH-1:0]  : '0;
        end
    end

    // A bank still flagged full must not be overwritten unless its last read is this cycle.
    wr_overlap_a: assert property (@(posedge clock) disable iff (reset)
        !(idata_en && full[wbank] && !(rd_last_c && (rbank == wbank))));

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder: single, back-to-back, gapped, resets, parameter sweep.
module tb_fft_reorder;

    logic        clock = 1'b0;
    logic        reset;

    logic        idata_en;
    logic [15:0] idata_r, idata_i;
    logic        odata_en;
    logic [15:0] odata_r, odata_i;

    logic        s_en;
    logic [7:0]  s_r, s_i;
    logic        so_en;
    logic [7:0]  so_r, so_i;

    logic        g_en;
    logic [23:0] g_r, g_i;
    logic        go_en;
    logic [23:0] go_r, go_i;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fft_reorder #(.WIDTH(16), .LOG2N(6)) dut (
        .clock(clock), .reset(reset),
        .idata_en(idata_en), .idata_r(idata_r), .idata_i(idata_i),
        .odata_en(odata_en), .odata_r(odata_r), .odata_i(odata_i)
    );

    fft_reorder #(.WIDTH(8), .LOG2N(2)) dut_small (
        .clock(clock), .reset(reset),
        .idata_en(s_en), .idata_r(s_r), .idata_i(s_i),
        .odata_en(so_en), .odata_r(so_r), .odata_i(so_i)
    );

    fft_reorder #(.WIDTH(24), .LOG2N(10)) dut_large (
        .clock(clock), .reset(reset),
        .idata_en(g_en), .idata_r(g_r), .idata_i(g_i),
        .odata_en(go_en), .odata_r(go_r), .odata_i(go_i)
    );

    function automatic int brev(input int v, input int nb);
        int r;
        r = 0;
        for (int b = 0; b < nb; b++)
            if (v[b]) r = r | (1 << (nb - 1 - b));
        return r;
    endfunction

    // Expected {en, r, i} at iteration j for 64-point frames whose last samples land at last0 + 64*f.
    function automatic logic [32:0] exp_main(input int j, input int last0, input int nfr);
        int n;
        for (int f = 0; f < nfr; f++) begin
            n = j - (last0 + 64 * f) - 3;
            if (n >= 0 && n < 64)
                return {1'b1, 16'((f << 12) | n), 16'(32'h8000 | n)};
        end
        return 33'd0;
    endfunction

    task automatic main_idle();
        idata_en = 1'b0;
        idata_r  = '0;
        idata_i  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        main_idle();
        s_en = 1'b0; s_r = '0; s_i = '0;
        g_en = 1'b0; g_r = '0; g_i = '0;
        repeat (2) @(negedge clock);
        checks++;
        if ({odata_en, odata_r, odata_i} !== 33'd0) begin
            failures++;
            $display("FAIL reset_main got=%h exp=0", {odata_en, odata_r, odata_i});
        end
        checks++;
        if ({so_en, so_r, so_i} !== 17'd0) begin
            failures++;
            $display("FAIL reset_small got=%h exp=0", {so_en, so_r, so_i});
        end
        checks++;
        if ({go_en, go_r, go_i} !== 49'd0) begin
            failures++;
            $display("FAIL reset_large got=%h exp=0", {go_en, go_r, go_i});
        end
        reset = 1'b0;
    endtask

    task automatic test_single_frame(input string tag);
        logic [32:0] e;
        for (int j = 0; j < 140; j++) begin
            @(negedge clock);
            e = exp_main(j, 63, 1);
            checks++;
            if ({odata_en, odata_r, odata_i} !== e) begin
                failures++;
                $display("FAIL %s j=%0d got=%h exp=%h", tag, j, {odata_en, odata_r, odata_i}, e);
            end
            if (j < 64) begin
                idata_en = 1'b1;
                idata_r  = 16'(brev(j, 6));
                idata_i  = 16'(32'h8000 | brev(j, 6));
            end else main_idle();
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e;
        for (int j = 0; j < 270; j++) begin
            @(negedge clock);
            e = exp_main(j, 63, 3);
            checks++;
            if ({odata_en, odata_r, odata_i} !== e) begin
                failures++;
                $display("FAIL back_to_back j=%0d got=%h exp=%h", j, {odata_en, odata_r, odata_i}, e);
            end
            if (j < 192) begin
                idata_en = 1'b1;
                idata_r  = 16'(((j / 64) << 12) | brev(j % 64, 6));
                idata_i  = 16'(32'h8000 | brev(j % 64, 6));
            end else main_idle();
        end
    endtask

    task automatic test_gapped();
        logic [32:0] e;
        for (int j = 0; j < 200; j++) begin
            @(negedge clock);
            e = exp_main(j, 126, 1);
            checks++;
            if ({odata_en, odata_r, odata_i} !== e) begin
                failures++;
                $display("FAIL gapped j=%0d got=%h exp=%h", j, {odata_en, odata_r, odata_i}, e);
            end
            if (j < 128 && (j % 2) == 0) begin
                idata_en = 1'b1;
                idata_r  = 16'(brev(j / 2, 6));
                idata_i  = 16'(32'h8000 | brev(j / 2, 6));
            end else main_idle();
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int j = 0; j < 20; j++) begin
            @(negedge clock);
            idata_en = 1'b1;
            idata_r  = 16'(16'h0bad ^ j);
            idata_i  = 16'(16'h7e00 | j);
        end
        @(negedge clock);
        main_idle();
        reset = 1'b1;
        #1;
        checks++;
        if ({odata_en, odata_r, odata_i} !== 33'd0) begin
            failures++;
            $display("FAIL rst_mid_frame got=%h exp=0", {odata_en, odata_r, odata_i});
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        test_single_frame("after_frame_reset");
    endtask

    task automatic test_reset_mid_read();
        logic [32:0] e;
        for (int j = 0; j < 77; j++) begin
            @(negedge clock);
            e = exp_main(j, 63, 1);
            checks++;
            if ({odata_en, odata_r, odata_i} !== e) begin
                failures++;
                $display("FAIL pre_rd_reset j=%0d got=%h exp=%h", j, {odata_en, odata_r, odata_i}, e);
            end
            if (j < 64) begin
                idata_en = 1'b1;
                idata_r  = 16'(brev(j, 6));
                idata_i  = 16'(32'h8000 | brev(j, 6));
            end else main_idle();
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({odata_en, odata_r, odata_i} !== 33'd0) begin
            failures++;
            $display("FAIL rst_mid_read got=%h exp=0", {odata_en, odata_r, odata_i});
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clock);
            checks++;
            if ({odata_en, odata_r, odata_i} !== 33'd0) begin
                failures++;
                $display("FAIL quiet_after_rd_reset j=%0d got=%h exp=0", j, {odata_en, odata_r, odata_i});
            end
        end
        test_single_frame("after_read_reset");
    endtask

    task automatic test_sweep_small();
        logic [16:0] e;
        int n;
        for (int j = 0; j < 20; j++) begin
            @(negedge clock);
            e = 17'd0;
            for (int f = 0; f < 2; f++) begin
                n = j - (3 + 4 * f) - 3;
                if (n >= 0 && n < 4) e = {1'b1, 8'(f * 16 + n), 8'(32'h40 + n)};
            end
            checks++;
            if ({so_en, so_r, so_i} !== e) begin
                failures++;
                $display("FAIL sweep_n4 j=%0d got=%h exp=%h", j, {so_en, so_r, so_i}, e);
            end
            if (j < 8) begin
                s_en = 1'b1;
                s_r  = 8'((j / 4) * 16 + brev(j % 4, 2));
                s_i  = 8'(32'h40 + brev(j % 4, 2));
            end else begin
                s_en = 1'b0; s_r = '0; s_i = '0;
            end
        end
    endtask

    task automatic test_sweep_large();
        logic [48:0] e;
        int n;
        for (int j = 0; j < 2060; j++) begin
            @(negedge clock);
            e = 49'd0;
            for (int f = 0; f < 2; f++) begin
                n = j - (1023 + 1024 * f) - 3;
                if (n >= 0 && n < 1024) e = {1'b1, 24'((f << 20) | n), 24'(32'h800000 | n)};
            end
            checks++;
            if ({go_en, go_r, go_i} !== e) begin
                failures++;
                $display("FAIL sweep_n1024 j=%0d got=%h exp=%h", j, {go_en, go_r, go_i}, e);
            end
            if (j < 2048) begin
                g_en = 1'b1;
                g_r  = 24'(((j / 1024) << 20) | brev(j % 1024, 10));
                g_i  = 24'(32'h800000 | brev(j % 1024, 10));
            end else begin
                g_en = 1'b0; g_r = '0; g_i = '0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame("single_frame");
        test_back_to_back();
        test_gapped();
        test_reset_mid_frame();
        test_reset_mid_read();
        test_sweep_small();
        test_sweep_large();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
